// File: rtl/btn_pkg.sv
// Shared defaults and width helper for the multi-channel button debouncer.
package btn_pkg;

  localparam int DEF_N_CH         = 4;
  localparam int DEF_TICK_DIV     = 100000;
  localparam int DEF_DEPTH        = 8;
  localparam int DEF_HOLD_TICKS   = 500;
  localparam int DEF_REPEAT_TICKS = 100;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) begin
      width = width + 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// Free-running sample-tick generator: o_tick is high for one clk every TICK_DIV clks.
module btn_tick_gen
  import btn_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = clog2_min1(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign o_tick = (count_reg == LAST);

endmodule

// File: rtl/multi_btn_debounce.sv
// N-channel button debouncer with press/release pulses and optional auto-repeat.
// Auto-repeat is built only when BTN_DEBOUNCE_REPEAT_EN is defined.
module multi_btn_debounce
  import btn_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_repeat
);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("N_CH must be 1..32");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 1");
  end
  if (DEPTH < 2 || DEPTH > 32) begin : g_bad_depth
    $error("DEPTH must be 2..32");
  end
  if (HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_repeat
    $error("HOLD_TICKS and REPEAT_TICKS must be at least 1");
  end

  logic tick;

  btn_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .o_tick(tick)
  );

  genvar gi;
  for (gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [1:0]       sync_reg;
    logic [DEPTH-1:0] hist_reg;
    logic [DEPTH-1:0] hist_next;
    logic             level_reg;
    logic             press_reg;
    logic             release_reg;
    logic             all_ones;
    logic             all_zeros;

    assign hist_next = (hist_reg << 1) | DEPTH'(sync_reg[1]);
    assign all_ones  = &hist_next;
    assign all_zeros = ~|hist_next;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_reg    <= '0;
        hist_reg    <= '0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        sync_reg    <= {sync_reg[0], i_btn[gi]};
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        if (tick) begin
          hist_reg <= hist_next;
          if (all_ones && !level_reg) begin
            level_reg <= 1'b1;
            press_reg <= 1'b1;
          end else if (all_zeros && level_reg) begin
            level_reg   <= 1'b0;
            release_reg <= 1'b1;
          end
        end
      end
    end

    assign o_level[gi]   = level_reg;
    assign o_press[gi]   = press_reg;
    assign o_release[gi] = release_reg;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int RW = clog2_min1(((HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS) + 1);

    logic [RW-1:0] rep_cnt_reg;
    logic [RW-1:0] rep_cnt_inc;
    logic [RW-1:0] rep_target;
    logic          rep_phase_reg;
    logic          repeat_reg;

    // First period counts up to HOLD_TICKS, every later period to REPEAT_TICKS.
    assign rep_cnt_inc = rep_cnt_reg + RW'(1);
    assign rep_target  = rep_phase_reg ? RW'(REPEAT_TICKS) : RW'(HOLD_TICKS);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rep_cnt_reg   <= '0;
        rep_phase_reg <= 1'b0;
        repeat_reg    <= 1'b0;
      end else begin
        repeat_reg <= 1'b0;
        if (tick) begin
          // A releasing tick clears the counter and must not emit a repeat.
          if (!level_reg || all_zeros) begin
            rep_cnt_reg   <= '0;
            rep_phase_reg <= 1'b0;
          end else if (rep_cnt_inc == rep_target) begin
            rep_cnt_reg   <= '0;
            rep_phase_reg <= 1'b1;
            repeat_reg    <= 1'b1;
          end else begin
            rep_cnt_reg <= rep_cnt_inc;
          end
        end
      end
    end

    assign o_repeat[gi] = repeat_reg;
`endif
  end

`ifndef BTN_DEBOUNCE_REPEAT_EN
  assign o_repeat = '0;
`endif

endmodule
